// File: rtl/frame_merge.sv
// Transmit frame merger: arbitrates ARP and UDP payload streams and
// prepends Ethernet / IPv4 / UDP headers. Optional macro: ETH_PAD_EN.
module frame_merge #(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678,
  parameter logic [7:0]  IP_TTL    = 8'h80
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  arp_tdata_in,
  input  logic        arp_tvalid_in,
  output logic        arp_tready_out,
  input  logic        arp_tlast_in,
  input  logic [47:0] arp_da_mac_in,
  input  logic [7:0]  udp_tdata_in,
  input  logic        udp_tvalid_in,
  output logic        udp_tready_out,
  input  logic        udp_tlast_in,
  input  logic [47:0] udp_da_mac_in,
  input  logic [31:0] udp_da_ip_in,
  input  logic [15:0] udp_sport_in,
  input  logic [15:0] udp_dport_in,
  input  logic [15:0] udp_length_in,
  output logic [7:0]  net_tdata_out,
  output logic        net_tvalid_out,
  input  logic        net_tready_in,
  output logic        net_tlast_out
);

  typedef enum logic [2:0] {
    IDLE,
    CHECKSUM,
    ETH_HEAD,
    IP_HEAD,
    UDP_HEAD,
    ARP_DATA,
`ifdef ETH_PAD_EN
    UDP_DATA,
    PAD
`else
    UDP_DATA
`endif
  } state_t;

  state_t      state_q;
  logic        is_arp_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [15:0] sport_q;
  logic [15:0] dport_q;
  logic [15:0] len_q;
  logic [15:0] id_q;
  logic [31:0] sum_q;
  logic [15:0] csum_q;
  logic [4:0]  cnt_q;
  logic [7:0]  tdata_q;
  logic        tvalid_q;
  logic        tlast_q;

  logic        ld;
  logic        in_data;
  logic        src_v;
  logic        src_l;
  logic [7:0]  src_d;
  logic [7:0]  hdr_d;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [31:0] sum_d;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        pad_now;

  logic [13:0][7:0] eth_a;
  logic [19:0][7:0] ip_a;
  logic [7:0][7:0]  udp_a;

  assign ld      = !tvalid_q || net_tready_in;
  assign in_data = (state_q == ARP_DATA) || (state_q == UDP_DATA);

  assign arp_tready_out = (state_q == ARP_DATA) && ld;
  assign udp_tready_out = (state_q == UDP_DATA) && ld;

  assign src_v = (state_q == ARP_DATA) ? arp_tvalid_in : udp_tvalid_in;
  assign src_l = (state_q == ARP_DATA) ? arp_tlast_in  : udp_tlast_in;
  assign src_d = (state_q == ARP_DATA) ? arp_tdata_in  : udp_tdata_in;

  assign tot_len = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  assign eth_a = {mac_q, LOCAL_MAC, 8'h08,
                  (is_arp_q ? 8'h06 : 8'h00)};
  assign ip_a  = {8'h45, 8'h00, tot_len, id_q, 16'h4000,
                  IP_TTL, 8'h11, csum_q, LOCAL_IP, ip_q};
  assign udp_a = {sport_q, dport_q, udp_len, 16'h0000};

  assign sum_d = 32'h0000_4500 + {16'h0, tot_len}
               + {16'h0, id_q} + 32'h0000_4000
               + {16'h0, IP_TTL, 8'h11}
               + {16'h0, LOCAL_IP[31:16]} + {16'h0, LOCAL_IP[15:0]}
               + {16'h0, ip_q[31:16]} + {16'h0, ip_q[15:0]};

  // first fold can carry at most once more; second fold cannot overflow
  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

  // header byte selected by the byte counter, MSB first
  always_comb begin
    hdr_d = 8'h00;
    unique case (state_q)
      ETH_HEAD: hdr_d = eth_a[4'd13 - cnt_q[3:0]];
      IP_HEAD:  hdr_d = ip_a[5'd19 - cnt_q];
      UDP_HEAD: hdr_d = udp_a[3'd7 - cnt_q[2:0]];
      default:  hdr_d = 8'h00;
    endcase
  end

`ifdef ETH_PAD_EN
  logic [10:0] fcnt_q;
  logic        emit;

  assign emit = ld && ((state_q == ETH_HEAD) || (state_q == IP_HEAD) ||
                       (state_q == UDP_HEAD) || (state_q == PAD) ||
                       (in_data && src_v));
  assign pad_now = (fcnt_q < 11'd59);

  // count emitted frame bytes so short frames can be padded to 60
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst)
      fcnt_q <= '0;
    else if (state_q == IDLE)
      fcnt_q <= '0;
    else if (emit)
      fcnt_q <= fcnt_q + 11'd1;
  end
`else
  assign pad_now = 1'b0;
`endif

  // frame sequencer with registered output stage
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_q  <= IDLE;
      is_arp_q <= 1'b0;
      mac_q    <= '0;
      ip_q     <= '0;
      sport_q  <= '0;
      dport_q  <= '0;
      len_q    <= '0;
      id_q     <= '0;
      sum_q    <= '0;
      csum_q   <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ld) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
          if (arp_tvalid_in) begin
            is_arp_q <= 1'b1;
            mac_q    <= arp_da_mac_in;
            state_q  <= ETH_HEAD;
          end else if (udp_tvalid_in) begin
            is_arp_q <= 1'b0;
            mac_q    <= udp_da_mac_in;
            ip_q     <= udp_da_ip_in;
            sport_q  <= udp_sport_in;
            dport_q  <= udp_dport_in;
            len_q    <= udp_length_in;
            state_q  <= CHECKSUM;
          end
        end
        CHECKSUM: begin
          if (ld)
            tvalid_q <= 1'b0;
          if (cnt_q == 5'd0) begin
            sum_q <= sum_d;
            cnt_q <= 5'd1;
          end else begin
            csum_q  <= ~fold2;
            cnt_q   <= '0;
            state_q <= ETH_HEAD;
          end
        end
        ETH_HEAD, IP_HEAD, UDP_HEAD: begin
          if (ld) begin
            tdata_q  <= hdr_d;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            cnt_q    <= cnt_q + 5'd1;
            if (state_q == ETH_HEAD && cnt_q == 5'd13) begin
              cnt_q   <= '0;
              state_q <= is_arp_q ? ARP_DATA : IP_HEAD;
            end
            if (state_q == IP_HEAD && cnt_q == 5'd19) begin
              cnt_q   <= '0;
              state_q <= UDP_HEAD;
            end
            if (state_q == UDP_HEAD && cnt_q == 5'd7) begin
              cnt_q   <= '0;
              state_q <= UDP_DATA;
            end
          end
        end
        ARP_DATA, UDP_DATA: begin
          if (ld) begin
            tvalid_q <= src_v;
            if (src_v) begin
              tdata_q <= src_d;
              tlast_q <= src_l && !pad_now;
              if (src_l) begin
`ifdef ETH_PAD_EN
                state_q <= pad_now ? PAD : IDLE;
`else
                state_q <= IDLE;
`endif
                if (state_q == UDP_DATA)
                  id_q <= id_q + 16'd1;
              end
            end
          end
        end
`ifdef ETH_PAD_EN
        PAD: begin
          if (ld) begin
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b1;
            tlast_q  <= !pad_now;
            if (!pad_now)
              state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign net_tdata_out  = tdata_q;
  assign net_tvalid_out = tvalid_q;
  assign net_tlast_out  = tlast_q;

endmodule

// File: tb/tb_frame_merge.sv
// Directed bench for frame_merge: ARP/UDP framing, stalls, priority,
// IP ID sequencing and mid-frame reset. Honours ETH_PAD_EN.
module tb_frame_merge;
  logic        logic_clk = 1'b0;
  logic        logic_rst = 1'b1;
  logic [7:0]  arp_tdata_in = '0;
  logic        arp_tvalid_in = 1'b0;
  logic        arp_tready_out;
  logic        arp_tlast_in = 1'b0;
  logic [47:0] arp_da_mac_in = '0;
  logic [7:0]  udp_tdata_in = '0;
  logic        udp_tvalid_in = 1'b0;
  logic        udp_tready_out;
  logic        udp_tlast_in = 1'b0;
  logic [47:0] udp_da_mac_in = '0;
  logic [31:0] udp_da_ip_in = '0;
  logic [15:0] udp_sport_in = '0;
  logic [15:0] udp_dport_in = '0;
  logic [15:0] udp_length_in = '0;
  logic [7:0]  net_tdata_out;
  logic        net_tvalid_out;
  logic        net_tready_in = 1'b1;
  logic        net_tlast_out;

  frame_merge dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .arp_tdata_in   (arp_tdata_in),
    .arp_tvalid_in  (arp_tvalid_in),
    .arp_tready_out (arp_tready_out),
    .arp_tlast_in   (arp_tlast_in),
    .arp_da_mac_in  (arp_da_mac_in),
    .udp_tdata_in   (udp_tdata_in),
    .udp_tvalid_in  (udp_tvalid_in),
    .udp_tready_out (udp_tready_out),
    .udp_tlast_in   (udp_tlast_in),
    .udp_da_mac_in  (udp_da_mac_in),
    .udp_da_ip_in   (udp_da_ip_in),
    .udp_sport_in   (udp_sport_in),
    .udp_dport_in   (udp_dport_in),
    .udp_length_in  (udp_length_in),
    .net_tdata_out  (net_tdata_out),
    .net_tvalid_out (net_tvalid_out),
    .net_tready_in  (net_tready_in),
    .net_tlast_out  (net_tlast_out)
  );

  always #5 logic_clk = ~logic_clk;

  localparam logic [47:0] UMAC = 48'h0200_0000_0001;

  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  rx[$];
  bit          rxl[$];
  int          base = 0;
  logic [7:0]  exp_q[$];
  bit          tog = 1'b0;
  bit          abort = 1'b0;
  logic [15:0] pat = 16'b1001_0110_1100_1001;
  logic [7:0]  hd;
  logic        hl;
  bit          hold = 1'b0;
  logic [7:0]  arp_pl[$];
  logic [7:0]  pl4[$];
  logic [7:0]  pl1[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // collect transferred bytes and check output holds during stalls
  always @(negedge logic_clk) begin
    if (hold && !logic_rst) begin
      chk("hold_valid", {31'h0, net_tvalid_out}, 32'h1);
      chk("hold_data", {24'h0, net_tdata_out}, {24'h0, hd});
      chk("hold_last", {31'h0, net_tlast_out}, {31'h0, hl});
    end
    hold = net_tvalid_out && !net_tready_in && !logic_rst;
    hd   = net_tdata_out;
    hl   = net_tlast_out;
    if (!logic_rst && net_tvalid_out && net_tready_in) begin
      rx.push_back(net_tdata_out);
      rxl.push_back(net_tlast_out);
    end
  end

  // downstream ready: constant or rotating stall pattern
  always @(posedge logic_clk) begin
    #1;
    if (tog) begin
      net_tready_in = pat[0];
      pat = {pat[0], pat[15:1]};
    end else begin
      net_tready_in = 1'b1;
    end
  end

  function automatic int count_last();
    int n = 0;
    for (int i = base; i < rxl.size(); i++)
      if (rxl[i]) n++;
    return n;
  endfunction

  task automatic send_arp(input logic [47:0] mac,
                          input logic [7:0] pl[$]);
    int i = 0;
    int c = 0;
    bit acc;
    arp_da_mac_in = mac;
    arp_tvalid_in = 1'b1;
    while (i < pl.size() && !abort && c < 3000) begin
      arp_tdata_in = pl[i];
      arp_tlast_in = (i == pl.size() - 1);
      @(negedge logic_clk);
      acc = arp_tready_out;
      @(posedge logic_clk);
      #1;
      c++;
      if (acc) i++;
    end
    if (c >= 3000) chk("arp_send_timeout", i, pl.size());
    arp_tvalid_in = 1'b0;
    arp_tlast_in  = 1'b0;
  endtask

  task automatic send_udp(input logic [15:0] len,
                          input logic [7:0] pl[$]);
    int i = 0;
    int c = 0;
    bit acc;
    udp_da_mac_in = UMAC;
    udp_da_ip_in  = 32'hC0A8_0001;
    udp_sport_in  = 16'h1234;
    udp_dport_in  = 16'h5678;
    udp_length_in = len;
    udp_tvalid_in = 1'b1;
    while (i < pl.size() && !abort && c < 3000) begin
      udp_tdata_in = pl[i];
      udp_tlast_in = (i == pl.size() - 1);
      @(negedge logic_clk);
      acc = udp_tready_out;
      @(posedge logic_clk);
      #1;
      c++;
      if (acc) i++;
    end
    if (c >= 3000) chk("udp_send_timeout", i, pl.size());
    udp_tvalid_in = 1'b0;
    udp_tlast_in  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (count_last() < n && c < 3000) begin
      @(posedge logic_clk);
      c++;
    end
    #1;
    chk("frame_wait", count_last(), n);
  endtask

  task automatic pushv(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--)
      exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic pad60();
`ifdef ETH_PAD_EN
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic build_arp();
    exp_q.delete();
    pushv(48'hFFFF_FFFF_FFFF, 6);
    pushv(48'hABCD_1234_5678, 6);
    pushv(48'h0806, 2);
    for (int i = 0; i < arp_pl.size(); i++) exp_q.push_back(arp_pl[i]);
    pad60();
  endtask

  task automatic build_udp(input logic [15:0] tot, input logic [15:0] id,
                           input logic [15:0] cs, input logic [15:0] ulen,
                           input logic [7:0] pl[$]);
    exp_q.delete();
    pushv(UMAC, 6);
    pushv(48'hABCD_1234_5678, 6);
    pushv(48'h0800, 2);
    pushv(48'h4500, 2);
    pushv({32'h0, tot}, 2);
    pushv({32'h0, id}, 2);
    pushv(48'h4000, 2);
    pushv(48'h8011, 2);
    pushv({32'h0, cs}, 2);
    pushv(48'hC0A8_006E, 4);
    pushv(48'hC0A8_0001, 4);
    pushv(48'h1234, 2);
    pushv(48'h5678, 2);
    pushv({32'h0, ulen}, 2);
    pushv(48'h0000, 2);
    for (int i = 0; i < pl.size(); i++) exp_q.push_back(pl[i]);
    pad60();
  endtask

  task automatic check_frame(input string tag);
    int n = 0;
    while (base + n < rx.size() && !rxl[base + n]) n++;
    if (base + n < rx.size()) n++;
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {24'h0, rx[base + i]},
          {24'h0, exp_q[i]});
    base = base + n;
  endtask

  task automatic chk_rst_state();
    chk("rst_tvalid", {31'h0, net_tvalid_out}, 32'h0);
    chk("rst_tlast", {31'h0, net_tlast_out}, 32'h0);
    chk("rst_tdata", {24'h0, net_tdata_out}, 32'h0);
    chk("rst_arp_rdy", {31'h0, arp_tready_out}, 32'h0);
    chk("rst_udp_rdy", {31'h0, udp_tready_out}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge logic_clk);
    #1 logic_rst = 1'b1;
    #2 chk_rst_state();
    @(posedge logic_clk);
    #1 logic_rst = 1'b0;
    base = rx.size();
  endtask

  initial begin
    for (int i = 0; i < 28; i++) arp_pl.push_back(8'h10 + 8'(i));
    pl4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    pl1 = '{8'h5A};

    #12 chk_rst_state();
    @(posedge logic_clk);
    #1 logic_rst = 1'b0;

    base = rx.size();
    send_arp(48'hFFFF_FFFF_FFFF, arp_pl);
    wait_frames(1);
    build_arp();
    check_frame("arp");

    do_reset();
    send_udp(16'd4, pl4);
    wait_frames(1);
    build_udp(16'h0020, 16'h0000, 16'h790D, 16'h000C, pl4);
    check_frame("udp4");

    do_reset();
    tog = 1'b1;
    send_udp(16'd4, pl4);
    wait_frames(1);
    tog = 1'b0;
    check_frame("udp_stall");

    do_reset();
    fork
      send_arp(48'hFFFF_FFFF_FFFF, arp_pl);
      send_udp(16'd4, pl4);
    join
    wait_frames(2);
    build_arp();
    check_frame("prio_arp");
    build_udp(16'h0020, 16'h0000, 16'h790D, 16'h000C, pl4);
    check_frame("prio_udp");
    send_udp(16'd4, pl4);
    wait_frames(1);
    build_udp(16'h0020, 16'h0001, 16'h790C, 16'h000C, pl4);
    check_frame("udp_id1");

    fork
      send_udp(16'd4, pl4);
      begin
        int c = 0;
        while (rx.size() - base < 30 && c < 3000) begin
          @(negedge logic_clk);
          c++;
        end
        chk("trunc_reach", rx.size() - base, 30);
        #2 logic_rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("trunc_tvalid", {31'h0, net_tvalid_out}, 32'h0);
        chk("trunc_tlast", {31'h0, net_tlast_out}, 32'h0);
        chk("trunc_nolast", count_last(), 0);
      end
    join
    @(posedge logic_clk);
    #1 logic_rst = 1'b0;
    abort = 1'b0;
    base = rx.size();
    send_udp(16'd4, pl4);
    wait_frames(1);
    build_udp(16'h0020, 16'h0000, 16'h790D, 16'h000C, pl4);
    check_frame("after_rst");

    send_udp(16'd1, pl1);
    wait_frames(1);
    build_udp(16'h001D, 16'h0001, 16'h790F, 16'h0009, pl1);
    check_frame("udp1");

    repeat (4) @(posedge logic_clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
